// File: rtl/mux_pkg.sv
// Shared definitions for the mux cell family: width limit, select encoding,
// and the X-masking select and parity helpers reused by mux trees.
package mux_pkg;

    localparam int MUX_MAX_WIDTH = 64;

    typedef enum logic {
        SEL_IN0 = 1'b0,
        SEL_IN1 = 1'b1
    } mux_sel_e;

    // The (a & b) consensus term keeps bits where a == b known even when s is unknown.
    function automatic logic [MUX_MAX_WIDTH-1:0] mux_sel(
        input logic [MUX_MAX_WIDTH-1:0] a,
        input logic [MUX_MAX_WIDTH-1:0] b,
        input logic                     s
    );
        return (a & b) | ({MUX_MAX_WIDTH{s}} & b) | ({MUX_MAX_WIDTH{~s}} & a);
    endfunction

    function automatic logic mux_parity(input logic [MUX_MAX_WIDTH-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/mux2_1_core.sv
// Purely combinational 2:1 leaf, y = s ? b : a, in bitwise form so that equal
// inputs mask an unknown select. Port order y, a, b, s matches existing leaf usage.
module mux2_1_core #(
    parameter int WIDTH = 1
) (
    output logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s
);

    assign y = (a & b) | ({WIDTH{s}} & b) | ({WIDTH{~s}} & a);

endmodule

// File: rtl/mux2_1_pipe.sv
// 2:1 mux leaf with a combinational output and a one-stage registered copy
// qualified by out_valid. Define MUX2_1_PIPE_PARITY_EN to add the y_par output.
module mux2_1_pipe
    import mux_pkg::*;
#(
    parameter int                         WIDTH   = 1,
    parameter logic [MUX_MAX_WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y_comb,
    output logic [WIDTH-1:0] y_q,
    output logic             out_valid
`ifdef MUX2_1_PIPE_PARITY_EN
    ,
    output logic             y_par
`endif
);

    localparam logic [WIDTH-1:0] RST_W = RST_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] sel_s;

    mux2_1_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .y (sel_s),
        .a (in0),
        .b (in1),
        .s (sel)
    );

    assign y_comb = sel_s;

    // Capture stage: y_q holds when in_valid is low, out_valid tracks the capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q       <= RST_W;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            y_q       <= sel_s;
            out_valid <= 1'b1;
        end else begin
            y_q       <= y_q;
            out_valid <= 1'b0;
        end
    end

`ifdef MUX2_1_PIPE_PARITY_EN
    localparam logic RST_PAR = mux_parity(MUX_MAX_WIDTH'(RST_W));

    // Parity is computed from the value being captured so it stays aligned with y_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_par <= RST_PAR;
        end else if (in_valid) begin
            y_par <= mux_parity(MUX_MAX_WIDTH'(sel_s));
        end else begin
            y_par <= y_par;
        end
    end
`endif

endmodule

// File: tb/tb_mux2_1_pipe.sv
// Directed self-checking bench for mux2_1_pipe (WIDTH=8 and WIDTH=1 instances).
module tb_mux2_1_pipe;

    logic       clk;
    logic       rst_n;
    logic [7:0] in0;
    logic [7:0] in1;
    logic       sel;
    logic       in_valid;
    logic [7:0] y_comb;
    logic [7:0] y_q;
    logic       out_valid;

    logic       w1_in0;
    logic       w1_in1;
    logic       w1_sel;
    logic       w1_y_comb;
    logic       w1_y_q;
    logic       w1_out_valid;

`ifdef MUX2_1_PIPE_PARITY_EN
    logic       y_par;
    logic       w1_y_par;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    mux2_1_pipe #(
        .WIDTH   (8),
        .RST_VAL (64'h5B)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0       (in0),
        .in1       (in1),
        .sel       (sel),
        .in_valid  (in_valid),
        .y_comb    (y_comb),
        .y_q       (y_q),
        .out_valid (out_valid)
`ifdef MUX2_1_PIPE_PARITY_EN
        ,
        .y_par     (y_par)
`endif
    );

    mux2_1_pipe #(
        .WIDTH   (1),
        .RST_VAL (64'h0)
    ) dut_w1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0       (w1_in0),
        .in1       (w1_in1),
        .sel       (w1_sel),
        .in_valid  (1'b0),
        .y_comb    (w1_y_comb),
        .y_q       (w1_y_q),
        .out_valid (w1_out_valid)
`ifdef MUX2_1_PIPE_PARITY_EN
        ,
        .y_par     (w1_y_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in0      = 8'h11;
        in1      = 8'h22;
        sel      = 1'b1;
        w1_in0   = 1'b0;
        w1_in1   = 1'b0;
        w1_sel   = 1'b0;

        // Reset held with in_valid=1: nothing gets captured
        tick();
        tick();
        check_eq("rst_y_q", 64'(y_q), 64'h5B);
        check_eq("rst_out_valid", 64'(out_valid), 64'h0);
`ifdef MUX2_1_PIPE_PARITY_EN
        check_eq("rst_y_par", 64'(y_par), 64'h1);
`endif

        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();
        check_eq("post_rst_out_valid", 64'(out_valid), 64'h0);
        check_eq("post_rst_y_q", 64'(y_q), 64'h5B);

        // Combinational select
        in0 = 8'hB6;
        in1 = 8'h49;
        sel = 1'b0;
        #1;
        check_eq("comb_sel0", 64'(y_comb), 64'hB6);
        sel = 1'b1;
        #1;
        check_eq("comb_sel1", 64'(y_comb), 64'h49);

        // Registered path, back-to-back valid
        in0      = 8'h11;
        in1      = 8'h22;
        sel      = 1'b1;
        in_valid = 1'b1;
        tick();
        check_eq("reg_e1_y_q", 64'(y_q), 64'h22);
        check_eq("reg_e1_valid", 64'(out_valid), 64'h1);
        sel = 1'b0;
        tick();
        check_eq("reg_e2_y_q", 64'(y_q), 64'h11);
        check_eq("reg_e2_valid", 64'(out_valid), 64'h1);
`ifdef MUX2_1_PIPE_PARITY_EN
        check_eq("par_11", 64'(y_par), 64'h0);
`endif
        in_valid = 1'b0;
        in0      = 8'hFF;
        in1      = 8'hEE;
        tick();
        check_eq("reg_e3_y_q_hold", 64'(y_q), 64'h11);
        check_eq("reg_e3_valid", 64'(out_valid), 64'h0);

        // Capture B6 through sel=0
        in0      = 8'hB6;
        in1      = 8'h00;
        sel      = 1'b0;
        in_valid = 1'b1;
        tick();
        check_eq("reg_b6_y_q", 64'(y_q), 64'hB6);
`ifdef MUX2_1_PIPE_PARITY_EN
        check_eq("par_b6", 64'(y_par), 64'h1);
`endif
        in_valid = 1'b0;
        tick();
`ifdef MUX2_1_PIPE_PARITY_EN
        check_eq("par_hold", 64'(y_par), 64'h1);
`endif

        // Equal inputs: select does not matter
        in0 = 8'b10110110;
        in1 = 8'b10110110;
        sel = 1'b0;
        #1;
        check_eq("eq_sel0", 64'(y_comb), 64'hB6);
        sel = 1'b1;
        #1;
        check_eq("eq_sel1", 64'(y_comb), 64'hB6);
        sel = 1'bx;
        #1;
        check_eq("eq_selx", 64'(y_comb), 64'hB6);

        w1_sel = 1'b0;
        #1;
        check_eq("w1_eq_sel0", 64'(w1_y_comb), 64'h0);
        w1_sel = 1'b1;
        #1;
        check_eq("w1_eq_sel1", 64'(w1_y_comb), 64'h0);
        w1_sel = 1'bx;
        #1;
        check_eq("w1_eq_selx", 64'(w1_y_comb), 64'h0);
        w1_in0 = 1'b0;
        w1_in1 = 1'b1;
        w1_sel = 1'b1;
        #1;
        check_eq("w1_sel1", 64'(w1_y_comb), 64'h1);
        check_eq("w1_y_q_rst", 64'(w1_y_q), 64'h0);

        // Async reset mid-stream
        in0      = 8'h3C;
        in1      = 8'hC3;
        sel      = 1'b1;
        in_valid = 1'b1;
        tick();
        check_eq("stream_y_q", 64'(y_q), 64'hC3);
        check_eq("stream_valid", 64'(out_valid), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_y_q", 64'(y_q), 64'h5B);
        check_eq("async_rst_valid", 64'(out_valid), 64'h0);
        check_eq("async_rst_y_comb", 64'(y_comb), 64'hC3);
`ifdef MUX2_1_PIPE_PARITY_EN
        check_eq("async_rst_y_par", 64'(y_par), 64'h1);
`endif
        tick();
        rst_n = 1'b1;
        sel   = 1'b0;
        tick();
        check_eq("after_rst_y_q", 64'(y_q), 64'h3C);
        check_eq("after_rst_valid", 64'(out_valid), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
